// File: rtl/jam1_alu_pkg.sv
// Shared types and constants for the JAM-1 ALU logic-unit sequencer.
package jam1_alu_pkg;

  localparam int LOGIC_SEL_W = 4;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN_LO = 2'd1,
    RUN_HI = 2'd2,
    RESP   = 2'd3
  } state_e;

  typedef struct packed {
    logic [LOGIC_SEL_W-1:0] op;
    logic                   wide;
    logic [15:0]            lhs;
    logic [15:0]            rhs;
    logic                   src;
  } req_t;

  function automatic logic [7:0] byte_sel(input logic [15:0] w, input logic hi);
    return hi ? w[15:8] : w[7:0];
  endfunction

endpackage

// File: rtl/alu_rr_arb2.sv
// Two-request round-robin arbiter; the pointer remembers who was granted last
// and only moves when a grant is actually issued.
module alu_rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic en_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  logic last_b_q, last_b_d;

  // last_b_q = 1 means B was granted last, so A wins the next tie
  always_comb begin
    gnt_a_o = en_i && req_a_i && (!req_b_i || last_b_q);
    gnt_b_o = en_i && req_b_i && (!req_a_i || !last_b_q);
  end

  always_comb begin
    last_b_d = last_b_q;
    if (gnt_a_o)      last_b_d = 1'b0;
    else if (gnt_b_o) last_b_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_b_q <= 1'b1;
    else       last_b_q <= last_b_d;
  end

endmodule

// File: rtl/alu_logic_sched.sv
// Two-port scheduler for the shared 8-bit logic unit; wide requests run as
// a low-byte pass followed by a high-byte pass.
module alu_logic_sched
  import jam1_alu_pkg::*;
#(
  parameter int LOGIC_LAT = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ReqAValid,
  output logic                   ReqAReady,
  input  logic [LOGIC_SEL_W-1:0] ReqAOp,
  input  logic                   ReqAWide,
  input  logic [15:0]            ReqALHS,
  input  logic [15:0]            ReqARHS,
  input  logic                   ReqBValid,
  output logic                   ReqBReady,
  input  logic [LOGIC_SEL_W-1:0] ReqBOp,
  input  logic                   ReqBWide,
  input  logic [15:0]            ReqBLHS,
  input  logic [15:0]            ReqBRHS,
  output logic                   RspValid,
  input  logic                   RspReady,
  output logic                   RspSrc,
  output logic [15:0]            RspData,
  output logic [LOGIC_SEL_W-1:0] LuSelect,
  output logic [7:0]             LuLHS,
  output logic [7:0]             LuRHS,
  input  logic [7:0]             LuResult,
  output logic                   Busy
);

  localparam logic [2:0] LAT_TC = 3'(LOGIC_LAT);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;
  logic [15:0] result_q, result_d;
  logic        gnt_a, gnt_b, arb_en, run, cnt_tc;

  // Gating with reset keeps Ready low while reset is held, even with Valid high
  assign arb_en = (state_q == IDLE) && !reset;
  assign run    = (state_q == RUN_LO) || (state_q == RUN_HI);
  assign cnt_tc = (cnt_q == LAT_TC);

  alu_rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req_a_i (ReqAValid),
    .req_b_i (ReqBValid),
    .en_i    (arb_en),
    .gnt_a_o (gnt_a),
    .gnt_b_o (gnt_b)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_a || gnt_b) state_d = RUN_LO;
      RUN_LO:  if (cnt_tc) state_d = req_q.wide ? RUN_HI : RESP;
      RUN_HI:  if (cnt_tc) state_d = RESP;
      RESP:    if (RspReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d    = req_q;
    cnt_d    = 3'd0;
    result_d = result_q;
    if (gnt_a) begin
      req_d.op   = ReqAOp;
      req_d.wide = ReqAWide;
      req_d.lhs  = ReqALHS;
      req_d.rhs  = ReqARHS;
      req_d.src  = SRC_A;
      result_d   = 16'h0000;
    end else if (gnt_b) begin
      req_d.op   = ReqBOp;
      req_d.wide = ReqBWide;
      req_d.lhs  = ReqBLHS;
      req_d.rhs  = ReqBRHS;
      req_d.src  = SRC_B;
      result_d   = 16'h0000;
    end
    // Counter wraps to 0 at terminal count so RUN_HI starts fresh
    if (run && !cnt_tc) cnt_d = cnt_q + 3'd1;
    if (run && cnt_tc) begin
      if (state_q == RUN_HI) result_d[15:8] = LuResult;
      else                   result_d[7:0]  = LuResult;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= 3'd0;
      req_q    <= '0;
      result_q <= 16'h0000;
    end else begin
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    ReqAReady = gnt_a;
    ReqBReady = gnt_b;
    LuSelect  = '0;
    LuLHS     = 8'h00;
    LuRHS     = 8'h00;
    RspValid  = 1'b0;
    RspSrc    = 1'b0;
    RspData   = 16'h0000;
    Busy      = (state_q != IDLE);
    if (run) begin
      LuSelect = req_q.op;
      LuLHS    = byte_sel(req_q.lhs, state_q == RUN_HI);
      LuRHS    = byte_sel(req_q.rhs, state_q == RUN_HI);
    end
    if (state_q == RESP) begin
      RspValid = 1'b1;
      RspSrc   = req_q.src;
      RspData  = result_q;
    end
  end

endmodule

// File: tb/tb_alu_logic_sched.sv
// Bench for alu_logic_sched: four instances (LOGIC_LAT 1..4) driven one at a
// time, each with an XOR logic-unit stub, checked against a transaction model.
module tb_alu_logic_sched;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic        a_valid [4], a_wide [4], a_ready [4];
  logic [3:0]  a_op [4];
  logic [15:0] a_lhs [4], a_rhs [4];
  logic        b_valid [4], b_wide [4], b_ready [4];
  logic [3:0]  b_op [4];
  logic [15:0] b_lhs [4], b_rhs [4];
  logic        rsp_valid [4], rsp_ready [4], rsp_src [4], busy [4];
  logic [15:0] rsp_data [4];
  logic [3:0]  lu_sel [4];
  logic [7:0]  lu_lhs [4], lu_rhs [4], lu_result [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int L = g + 1;
    logic [7:0] pipe [L];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < L; i++) pipe[i] <= 8'h00;
      end else begin
        pipe[0] <= lu_lhs[g] ^ lu_rhs[g];
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
      end
    end
    assign lu_result[g] = pipe[L-1];

    alu_logic_sched #(.LOGIC_LAT(L)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .ReqAValid (a_valid[g]),
      .ReqAReady (a_ready[g]),
      .ReqAOp    (a_op[g]),
      .ReqAWide  (a_wide[g]),
      .ReqALHS   (a_lhs[g]),
      .ReqARHS   (a_rhs[g]),
      .ReqBValid (b_valid[g]),
      .ReqBReady (b_ready[g]),
      .ReqBOp    (b_op[g]),
      .ReqBWide  (b_wide[g]),
      .ReqBLHS   (b_lhs[g]),
      .ReqBRHS   (b_rhs[g]),
      .RspValid  (rsp_valid[g]),
      .RspReady  (rsp_ready[g]),
      .RspSrc    (rsp_src[g]),
      .RspData   (rsp_data[g]),
      .LuSelect  (lu_sel[g]),
      .LuLHS     (lu_lhs[g]),
      .LuRHS     (lu_rhs[g]),
      .LuResult  (lu_result[g]),
      .Busy      (busy[g])
    );
  end

  task automatic drive(input int k, input bit pb, input logic v, input logic w,
                       input logic [3:0] op, input logic [15:0] l, input logic [15:0] r);
    if (pb) begin
      b_valid[k] = v; b_wide[k] = w; b_op[k] = op; b_lhs[k] = l; b_rhs[k] = r;
    end else begin
      a_valid[k] = v; a_wide[k] = w; a_op[k] = op; a_lhs[k] = l; a_rhs[k] = r;
    end
  endtask

  function automatic logic [15:0] model_result(input logic w, input logic [15:0] l, input logic [15:0] r);
    return w ? (l ^ r) : {8'h00, l[7:0] ^ r[7:0]};
  endfunction

  // One full transaction with RspReady held high; optionally the other port
  // requests at the same time and must lose.
  task automatic run_one(input int k, input bit pb, input logic wide, input logic [3:0] op,
                         input logic [15:0] lhs, input logic [15:0] rhs, input bit both);
    int lat, exp_lat;
    bit bad_ready;
    logic [15:0] exp_data;
    logic win_rdy, lose_rdy;
    exp_lat  = wide ? 3 + 2 * (k + 1) : 2 + (k + 1);
    exp_data = model_result(wide, lhs, rhs);
    lat = -1;
    bad_ready = 1'b0;
    rsp_ready[k] = 1'b1;
    @(posedge clk); #1;
    drive(k, pb, 1'b1, wide, op, lhs, rhs);
    if (both) drive(k, !pb, 1'b1, 1'($urandom), 4'($urandom), 16'($urandom), 16'($urandom));
    @(negedge clk);
    win_rdy  = pb ? b_ready[k] : a_ready[k];
    lose_rdy = pb ? a_ready[k] : b_ready[k];
    tests++;
    if (win_rdy !== 1'b1 || lose_rdy !== 1'b0)
      begin fails++; $display("FAIL grant k=%0d port=%0d got win=%b lose=%b exp win=1 lose=0", k, pb, win_rdy, lose_rdy); end
    @(posedge clk); #1;
    drive(k, pb, 1'b0, 1'($urandom), 4'($urandom), 16'($urandom), 16'($urandom));
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (a_ready[k] || b_ready[k]) bad_ready = 1'b1;
      if (n == 1) begin
        tests++;
        if (lu_sel[k] !== op || lu_lhs[k] !== lhs[7:0] || lu_rhs[k] !== rhs[7:0])
          begin fails++; $display("FAIL lu_lo k=%0d got sel=%h lhs=%h rhs=%h exp sel=%h lhs=%h rhs=%h",
                                  k, lu_sel[k], lu_lhs[k], lu_rhs[k], op, lhs[7:0], rhs[7:0]); end
      end
      if (wide && n == 2 + (k + 1)) begin
        tests++;
        if (lu_sel[k] !== op || lu_lhs[k] !== lhs[15:8] || lu_rhs[k] !== rhs[15:8])
          begin fails++; $display("FAIL lu_hi k=%0d got sel=%h lhs=%h rhs=%h exp sel=%h lhs=%h rhs=%h",
                                  k, lu_sel[k], lu_lhs[k], lu_rhs[k], op, lhs[15:8], rhs[15:8]); end
      end
      if (rsp_valid[k]) begin lat = n; break; end
    end
    tests++;
    if (lat != exp_lat)
      begin fails++; $display("FAIL latency k=%0d wide=%0d got %0d exp %0d", k, wide, lat, exp_lat); end
    tests++;
    if (rsp_data[k] !== exp_data || rsp_src[k] !== pb)
      begin fails++; $display("FAIL rsp k=%0d got data=%h src=%b exp data=%h src=%b", k, rsp_data[k], rsp_src[k], exp_data, pb); end
    tests++;
    if (bad_ready)
      begin fails++; $display("FAIL ready_while_busy k=%0d got ready high exp low", k); end
    if (both) begin
      if (pb) a_valid[k] = 1'b0;
      else    b_valid[k] = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(k, 1'b0, 1'b1, 1'b0, 4'h0, 16'h0, 16'h0);
      drive(k, 1'b1, 1'b1, 1'b0, 4'h0, 16'h0, 16'h0);
      rsp_ready[k] = 1'b1;
    end
    #1;
    for (int k = 0; k < 4; k++) begin
      tests++;
      if ({a_ready[k], b_ready[k], rsp_valid[k], rsp_src[k], rsp_data[k], lu_sel[k], lu_lhs[k], lu_rhs[k], busy[k]} !== '0)
        begin fails++; $display("FAIL reset_outputs k=%0d got rdy=%b%b rv=%b data=%h busy=%b exp all zero",
                                k, a_ready[k], b_ready[k], rsp_valid[k], rsp_data[k], busy[k]); end
      a_valid[k] = 1'b0;
      b_valid[k] = 1'b0;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_narrow;
    run_one(0, 1'b0, 1'b0, 4'h6, 16'h00F0, 16'h003C, 1'b0);
  endtask

  task automatic test_wide;
    run_one(1, 1'b1, 1'b1, 4'h6, 16'hA55A, 16'hFF00, 1'b0);
  endtask

  task automatic test_tie;
    int grants, rsps;
    bit dbl;
    logic [15:0] exp_data;
    grants = 0; rsps = 0; dbl = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1; reset = 1'b0;
    rsp_ready[0] = 1'b1;
    drive(0, 1'b0, 1'b1, 1'b0, 4'h3, 16'h1111, 16'h2222);
    drive(0, 1'b1, 1'b1, 1'b1, 4'h5, 16'hABCD, 16'h0F0F);
    for (int c = 0; c < 200 && grants < 4; c++) begin
      @(negedge clk);
      if (a_ready[0] && b_ready[0]) dbl = 1'b1;
      if (rsp_valid[0]) begin
        exp_data = rsp_src[0] ? model_result(1'b1, 16'hABCD, 16'h0F0F) : model_result(1'b0, 16'h1111, 16'h2222);
        tests++;
        if (rsp_src[0] !== 1'(rsps % 2) || rsp_data[0] !== exp_data)
          begin fails++; $display("FAIL tie_rsp n=%0d got src=%b data=%h exp src=%0d data=%h",
                                  rsps, rsp_src[0], rsp_data[0], rsps % 2, exp_data); end
        rsps++;
      end
      if (a_ready[0] || b_ready[0]) begin
        tests++;
        if (b_ready[0] !== 1'(grants % 2))
          begin fails++; $display("FAIL tie_order n=%0d got b_ready=%b exp %0d", grants, b_ready[0], grants % 2); end
        grants++;
      end
    end
    tests++;
    if (grants != 4 || dbl)
      begin fails++; $display("FAIL tie_progress got grants=%0d double=%b exp 4 0", grants, dbl); end
    @(posedge clk); #1;
    a_valid[0] = 1'b0;
    b_valid[0] = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (rsp_valid[0]) break;
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    bit seen, stable;
    logic [15:0] exp_a, exp_b;
    exp_a = model_result(1'b0, 16'h3C5A, 16'h0F99);
    exp_b = model_result(1'b1, 16'h7E81, 16'h1234);
    seen = 1'b0;
    rsp_ready[1] = 1'b0;
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b1, 1'b0, 4'h9, 16'h3C5A, 16'h0F99);
    @(negedge clk);
    tests++;
    if (a_ready[1] !== 1'b1)
      begin fails++; $display("FAIL bp_grant got a_ready=%b exp 1", a_ready[1]); end
    @(posedge clk); #1;
    a_valid[1] = 1'b0;
    drive(1, 1'b1, 1'b1, 1'b1, 4'h2, 16'h7E81, 16'h1234);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (rsp_valid[1]) begin seen = 1'b1; break; end
    end
    tests++;
    if (!seen) begin fails++; $display("FAIL bp_rsp_timeout got none exp RspValid"); end
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      stable = (rsp_valid[1] === 1'b1) && (rsp_data[1] === exp_a) && (rsp_src[1] === 1'b0)
               && (a_ready[1] === 1'b0) && (b_ready[1] === 1'b0);
      tests++;
      if (!stable)
        begin fails++; $display("FAIL bp_hold c=%0d got rv=%b data=%h src=%b rdy=%b%b exp 1 %h 0 00",
                                c, rsp_valid[1], rsp_data[1], rsp_src[1], a_ready[1], b_ready[1], exp_a); end
    end
    @(posedge clk); #1;
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    tests++;
    if (rsp_valid[1] !== 1'b1 || b_ready[1] !== 1'b0)
      begin fails++; $display("FAIL bp_release got rv=%b b_ready=%b exp 1 0", rsp_valid[1], b_ready[1]); end
    @(negedge clk);
    tests++;
    if (rsp_valid[1] !== 1'b0 || b_ready[1] !== 1'b1)
      begin fails++; $display("FAIL bp_next_grant got rv=%b b_ready=%b exp 0 1", rsp_valid[1], b_ready[1]); end
    @(posedge clk); #1;
    b_valid[1] = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (rsp_valid[1]) begin seen = 1'b1; break; end
    end
    tests++;
    if (!seen || rsp_data[1] !== exp_b || rsp_src[1] !== 1'b1)
      begin fails++; $display("FAIL bp_second got seen=%b data=%h src=%b exp 1 %h 1", seen, rsp_data[1], rsp_src[1], exp_b); end
  endtask

  task automatic test_reset_mid;
    bit leak;
    leak = 1'b0;
    rsp_ready[2] = 1'b1;
    @(posedge clk); #1;
    drive(2, 1'b0, 1'b1, 1'b1, 4'hC, 16'hBEEF, 16'h5AA5);
    @(negedge clk);
    tests++;
    if (a_ready[2] !== 1'b1)
      begin fails++; $display("FAIL rst_mid_grant got a_ready=%b exp 1", a_ready[2]); end
    @(posedge clk); #1;
    a_valid[2] = 1'b0;
    repeat (6) @(negedge clk);
    tests++;
    if (lu_lhs[2] !== 8'hBE || busy[2] !== 1'b1)
      begin fails++; $display("FAIL rst_mid_run_hi got lhs=%h busy=%b exp BE 1", lu_lhs[2], busy[2]); end
    #1;
    reset = 1'b1;
    a_valid[2] = 1'b1;
    b_valid[2] = 1'b1;
    #1;
    tests++;
    if ({a_ready[2], b_ready[2], rsp_valid[2], rsp_src[2], rsp_data[2], lu_sel[2], lu_lhs[2], lu_rhs[2], busy[2]} !== '0)
      begin fails++; $display("FAIL rst_mid_outputs got rdy=%b%b rv=%b sel=%h lhs=%h busy=%b exp all zero",
                              a_ready[2], b_ready[2], rsp_valid[2], lu_sel[2], lu_lhs[2], busy[2]); end
    a_valid[2] = 1'b0;
    b_valid[2] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (rsp_valid[2] || busy[2]) leak = 1'b1;
    end
    tests++;
    if (leak) begin fails++; $display("FAIL rst_mid_abandon got response or busy exp none"); end
    run_one(2, 1'b0, 1'b0, 4'h1, 16'h0123, 16'h4567, 1'b1);
  endtask

  task automatic test_sweep;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 6; i++) begin
        run_one(k, 1'($urandom_range(0, 1)), 1'(i % 2), 4'($urandom),
                16'($urandom), 16'($urandom), 1'b0);
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 6; i++)
      run_one(3, 1'(i % 2), 1'($urandom_range(0, 1)), 4'($urandom), 16'($urandom), 16'($urandom), 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 4; k++) begin
      drive(k, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
      drive(k, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
      rsp_ready[k] = 1'b0;
    end
    test_reset();
    test_narrow();
    test_wide();
    test_tie();
    test_backpressure();
    test_reset_mid();
    test_sweep();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
